// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a two-state IDLE/ACCESS FSM.
// ALU ops retire in one cycle. Loads/stores hold a memory request
// until MemAck, stalling Execute while the access is outstanding.
// Optional abort of a hung access with a MemErr pulse, enabled by
// defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
// Ports:
//   clk, reset                        clock, sync active-high reset
//   ValidE, ALUResultE, WriteDataE    instruction from Execute
//   RegWriteE, MemWriteE, MemtoRegE   control bits from Execute
//   WA3E                              destination register index
//   FlushM                            discard instruction in stage
//   StallE                            hold Execute (state==ACCESS)
//   MemReq, MemWe, MemAddr, MemWData  data-memory request
//   MemAck, MemRData                  data-memory response
//   ValidW, RegWriteW, MemtoRegW      Writeback valid/control
//   ALUOutW, ReadDataW, WA3W          Writeback data/index
//   MemErr                            one-cycle pulse on abort
module mem_stage #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             MemtoRegE,
    input  logic [3:0]       WA3E,
    input  logic             FlushM,
    output logic             StallE,
    output logic             MemReq,
    output logic             MemWe,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWData,
    input  logic             MemAck,
    input  logic [WIDTH-1:0] MemRData,
    output logic             ValidW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [WIDTH-1:0] ALUOutW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [3:0]       WA3W,
    output logic             MemErr
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_flush_pend;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic             r_we;
    logic             r_rw;
    logic             r_m2r;
    logic [3:0]       r_wa3;

    logic             r_valid_w;
    logic             r_regwrite_w;
    logic             r_memtoreg_w;
    logic [WIDTH-1:0] r_alu_out_w;
    logic [WIDTH-1:0] r_read_data_w;
    logic [3:0]       r_wa3_w;

    logic w_access;
    logic w_is_mem;
    logic w_accept;
    logic w_flush;
    logic w_timeout;

    assign w_access = (r_state == ACCESS);
    assign w_is_mem = MemWriteE | MemtoRegE;
    assign w_accept = ValidE & ~FlushM;
    // A flush seen in the ack cycle itself also kills the retirement.
    assign w_flush  = r_flush_pend | FlushM;

    assign StallE    = w_access;
    assign MemReq    = w_access;
    assign MemWe     = r_we;
    assign MemAddr   = r_addr;
    assign MemWData  = r_wdata;
    assign ValidW    = r_valid_w;
    assign RegWriteW = r_regwrite_w;
    assign MemtoRegW = r_memtoreg_w;
    assign ALUOutW   = r_alu_out_w;
    assign ReadDataW = r_read_data_w;
    assign WA3W      = r_wa3_w;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Counts ACCESS cycles without an ack; aborts on the last one.
    assign w_timeout = w_access & ~MemAck & (r_cnt == TO_LAST);
    assign MemErr    = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_timeout) begin
                r_cnt <= '0;
                r_err <= 1'b1;
            end else if (w_access && !MemAck) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign MemErr    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_flush_pend  <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_rw          <= 1'b0;
            r_m2r         <= 1'b0;
            r_wa3         <= '0;
            r_valid_w     <= 1'b0;
            r_regwrite_w  <= 1'b0;
            r_memtoreg_w  <= 1'b0;
            r_alu_out_w   <= '0;
            r_read_data_w <= '0;
            r_wa3_w       <= '0;
        end else begin
            // Writeback valid is a pulse; control is cleared with it.
            r_valid_w    <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept && w_is_mem) begin
                        r_addr       <= ALUResultE;
                        r_wdata      <= WriteDataE;
                        r_we         <= MemWriteE;
                        r_rw         <= RegWriteE;
                        r_m2r        <= MemtoRegE;
                        r_wa3        <= WA3E;
                        r_flush_pend <= 1'b0;
                        r_state      <= ACCESS;
                    end else if (w_accept) begin
                        r_valid_w    <= 1'b1;
                        r_regwrite_w <= RegWriteE;
                        r_memtoreg_w <= MemtoRegE;
                        r_alu_out_w  <= ALUResultE;
                        r_wa3_w      <= WA3E;
                    end
                end
                ACCESS: begin
                    if (MemAck) begin
                        r_state      <= IDLE;
                        r_we         <= 1'b0;
                        r_flush_pend <= 1'b0;
                        if (!w_flush) begin
                            r_valid_w    <= 1'b1;
                            r_regwrite_w <= r_rw;
                            r_memtoreg_w <= r_m2r;
                            r_alu_out_w  <= r_addr;
                            r_wa3_w      <= r_wa3;
                            if (r_m2r) begin
                                r_read_data_w <= MemRData;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state      <= IDLE;
                        r_we         <= 1'b0;
                        r_flush_pend <= 1'b0;
                    end else if (FlushM) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Drives inputs #1 after each rising edge and samples there too.
module tb_mem_stage;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         ValidE;
    logic [W-1:0] ALUResultE;
    logic [W-1:0] WriteDataE;
    logic         RegWriteE;
    logic         MemWriteE;
    logic         MemtoRegE;
    logic [3:0]   WA3E;
    logic         FlushM;
    logic         StallE;
    logic         MemReq;
    logic         MemWe;
    logic [W-1:0] MemAddr;
    logic [W-1:0] MemWData;
    logic         MemAck;
    logic [W-1:0] MemRData;
    logic         ValidW;
    logic         RegWriteW;
    logic         MemtoRegW;
    logic [W-1:0] ALUOutW;
    logic [W-1:0] ReadDataW;
    logic [3:0]   WA3W;
    logic         MemErr;

    int total = 0;
    int bad   = 0;

    mem_stage #(
        .WIDTH(W),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ValidE(ValidE),
        .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE),
        .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE),
        .MemtoRegE(MemtoRegE),
        .WA3E(WA3E),
        .FlushM(FlushM),
        .StallE(StallE),
        .MemReq(MemReq),
        .MemWe(MemWe),
        .MemAddr(MemAddr),
        .MemWData(MemWData),
        .MemAck(MemAck),
        .MemRData(MemRData),
        .ValidW(ValidW),
        .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW),
        .ALUOutW(ALUOutW),
        .ReadDataW(ReadDataW),
        .WA3W(WA3W),
        .MemErr(MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ValidE     = 1'b0;
        ALUResultE = '0;
        WriteDataE = '0;
        RegWriteE  = 1'b0;
        MemWriteE  = 1'b0;
        MemtoRegE  = 1'b0;
        WA3E       = '0;
        FlushM     = 1'b0;
        MemAck     = 1'b0;
        MemRData   = '0;
    endtask

    task automatic issue_load(input logic [W-1:0] a, input logic [3:0] wa);
        ValidE     = 1'b1;
        MemtoRegE  = 1'b1;
        RegWriteE  = 1'b1;
        ALUResultE = a;
        WA3E       = wa;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++;
        if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || MemtoRegW !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: ValidW=%b RegWriteW=%b MemtoRegW=%b want 000",
                     ValidW, RegWriteW, MemtoRegW);
        end
        total++;
        if (StallE !== 1'b0 || MemReq !== 1'b0 || MemWe !== 1'b0 || MemErr !== 1'b0) begin
            bad++;
            $display("FAIL reset_mem: StallE=%b MemReq=%b MemWe=%b MemErr=%b want 0000",
                     StallE, MemReq, MemWe, MemErr);
        end
        total++;
        if (ALUOutW !== '0 || ReadDataW !== '0 || MemAddr !== '0 || MemWData !== '0 || WA3W !== 4'd0) begin
            bad++;
            $display("FAIL reset_data: ALUOutW=%h ReadDataW=%h MemAddr=%h MemWData=%h WA3W=%0d want 0",
                     ALUOutW, ReadDataW, MemAddr, MemWData, WA3W);
        end
    endtask

    task automatic test_alu;
        ValidE     = 1'b1;
        ALUResultE = 32'h0000_0014;
        RegWriteE  = 1'b1;
        WA3E       = 4'd3;
        total++;
        if (StallE !== 1'b0) begin
            bad++;
            $display("FAIL alu_stall_pre: got %b want 0", StallE);
        end
        step();
        idle_inputs();
        total++;
        if (ValidW !== 1'b1 || ALUOutW !== 32'h14 || WA3W !== 4'd3 || RegWriteW !== 1'b1) begin
            bad++;
            $display("FAIL alu_retire: ValidW=%b ALUOutW=%h WA3W=%0d RegWriteW=%b want 1 14 3 1",
                     ValidW, ALUOutW, WA3W, RegWriteW);
        end
        total++;
        if (StallE !== 1'b0 || MemReq !== 1'b0) begin
            bad++;
            $display("FAIL alu_stall: StallE=%b MemReq=%b want 0 0", StallE, MemReq);
        end
        step();
        total++;
        if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin
            bad++;
            $display("FAIL alu_pulse: ValidW=%b RegWriteW=%b want 0 0", ValidW, RegWriteW);
        end
    endtask

    task automatic test_load;
        issue_load(32'h100, 4'd5);
        MemAck = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (MemReq !== 1'b1 || StallE !== 1'b1 || MemAddr !== 32'h100 || MemWe !== 1'b0) begin
                bad++;
                $display("FAIL load_access%0d: MemReq=%b StallE=%b MemAddr=%h MemWe=%b want 1 1 100 0",
                         i, MemReq, StallE, MemAddr, MemWe);
            end
            if (i == 2) begin
                MemAck     = 1'b1;
                MemRData   = 32'hDEAD_BEEF;
                ValidE     = 1'b1;
                ALUResultE = 32'h77;
                RegWriteE  = 1'b1;
                WA3E       = 4'd9;
            end
            step();
        end
        idle_inputs();
        total++;
        if (ValidW !== 1'b1 || ReadDataW !== 32'hDEAD_BEEF || WA3W !== 4'd5 || ALUOutW !== 32'h100) begin
            bad++;
            $display("FAIL load_retire: ValidW=%b ReadDataW=%h WA3W=%0d ALUOutW=%h want 1 deadbeef 5 100",
                     ValidW, ReadDataW, WA3W, ALUOutW);
        end
        total++;
        if (RegWriteW !== 1'b1 || MemtoRegW !== 1'b1 || StallE !== 1'b0 || MemReq !== 1'b0) begin
            bad++;
            $display("FAIL load_ctl: RegWriteW=%b MemtoRegW=%b StallE=%b MemReq=%b want 1 1 0 0",
                     RegWriteW, MemtoRegW, StallE, MemReq);
        end
        step();
        total++;
        if (ValidW !== 1'b0) begin
            bad++;
            $display("FAIL load_ignored_op: ValidW=%b want 0", ValidW);
        end
    endtask

    task automatic test_store;
        ValidE     = 1'b1;
        MemWriteE  = 1'b1;
        ALUResultE = 32'h40;
        WriteDataE = 32'hA5A5_A5A5;
        step();
        idle_inputs();
        MemAck = 1'b1;
        total++;
        if (MemWe !== 1'b1 || MemWData !== 32'hA5A5_A5A5 || MemReq !== 1'b1 || MemAddr !== 32'h40) begin
            bad++;
            $display("FAIL store_req: MemWe=%b MemWData=%h MemReq=%b MemAddr=%h want 1 a5a5a5a5 1 40",
                     MemWe, MemWData, MemReq, MemAddr);
        end
        step();
        MemAck = 1'b0;
        total++;
        if (ValidW !== 1'b1 || RegWriteW !== 1'b0 || StallE !== 1'b0) begin
            bad++;
            $display("FAIL store_retire: ValidW=%b RegWriteW=%b StallE=%b want 1 0 0",
                     ValidW, RegWriteW, StallE);
        end
        total++;
        if (ReadDataW !== 32'hDEAD_BEEF || MemWe !== 1'b0) begin
            bad++;
            $display("FAIL store_hold: ReadDataW=%h MemWe=%b want deadbeef 0", ReadDataW, MemWe);
        end
        step();
    endtask

    task automatic test_flush_access;
        issue_load(32'h200, 4'd7);
        step();
        idle_inputs();
        step();
        FlushM = 1'b1;
        step();
        FlushM = 1'b0;
        step();
        total++;
        if (MemReq !== 1'b1 || StallE !== 1'b1) begin
            bad++;
            $display("FAIL flush_runs: MemReq=%b StallE=%b want 1 1", MemReq, StallE);
        end
        MemAck   = 1'b1;
        MemRData = 32'h1234_5678;
        step();
        idle_inputs();
        total++;
        if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || StallE !== 1'b0) begin
            bad++;
            $display("FAIL flush_retire: ValidW=%b RegWriteW=%b StallE=%b want 0 0 0",
                     ValidW, RegWriteW, StallE);
        end
        ValidE     = 1'b1;
        ALUResultE = 32'h33;
        RegWriteE  = 1'b1;
        WA3E       = 4'd2;
        step();
        idle_inputs();
        total++;
        if (ValidW !== 1'b1 || ALUOutW !== 32'h33 || WA3W !== 4'd2) begin
            bad++;
            $display("FAIL flush_clear: ValidW=%b ALUOutW=%h WA3W=%0d want 1 33 2",
                     ValidW, ALUOutW, WA3W);
        end
        step();
    endtask

    task automatic test_flush_idle;
        issue_load(32'h300, 4'd1);
        FlushM = 1'b1;
        step();
        idle_inputs();
        total++;
        if (StallE !== 1'b0 || MemReq !== 1'b0 || ValidW !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_mem: StallE=%b MemReq=%b ValidW=%b want 0 0 0",
                     StallE, MemReq, ValidW);
        end
        ValidE     = 1'b1;
        ALUResultE = 32'h44;
        RegWriteE  = 1'b1;
        FlushM     = 1'b1;
        step();
        idle_inputs();
        total++;
        if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_alu: ValidW=%b RegWriteW=%b want 0 0", ValidW, RegWriteW);
        end
    endtask

    task automatic test_reset_access;
        issue_load(32'h400, 4'd6);
        step();
        idle_inputs();
        step();
        reset  = 1'b1;
        MemAck = 1'b1;
        step();
        reset  = 1'b0;
        MemAck = 1'b0;
        total++;
        if (MemReq !== 1'b0 || StallE !== 1'b0 || ValidW !== 1'b0) begin
            bad++;
            $display("FAIL rst_access: MemReq=%b StallE=%b ValidW=%b want 0 0 0",
                     MemReq, StallE, ValidW);
        end
        ValidE     = 1'b1;
        ALUResultE = 32'h55;
        RegWriteE  = 1'b1;
        WA3E       = 4'd4;
        step();
        idle_inputs();
        total++;
        if (ValidW !== 1'b1 || ALUOutW !== 32'h55 || WA3W !== 4'd4 || RegWriteW !== 1'b1) begin
            bad++;
            $display("FAIL rst_next_alu: ValidW=%b ALUOutW=%h WA3W=%0d RegWriteW=%b want 1 55 4 1",
                     ValidW, ALUOutW, WA3W, RegWriteW);
        end
        step();
    endtask

    task automatic test_timeout;
        issue_load(32'h500, 4'd8);
        step();
        idle_inputs();
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            total++;
            if (StallE !== 1'b1 || MemErr !== 1'b0) begin
                bad++;
                $display("FAIL to_wait%0d: StallE=%b MemErr=%b want 1 0", i, StallE, MemErr);
            end
            step();
        end
        total++;
        if (MemErr !== 1'b1 || StallE !== 1'b0 || MemReq !== 1'b0 || ValidW !== 1'b0) begin
            bad++;
            $display("FAIL to_abort: MemErr=%b StallE=%b MemReq=%b ValidW=%b want 1 0 0 0",
                     MemErr, StallE, MemReq, ValidW);
        end
        step();
        total++;
        if (MemErr !== 1'b0) begin
            bad++;
            $display("FAIL to_pulse: MemErr=%b want 0", MemErr);
        end
`else
        repeat (100) step();
        total++;
        if (StallE !== 1'b1 || MemReq !== 1'b1 || MemErr !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout: StallE=%b MemReq=%b MemErr=%b want 1 1 0",
                     StallE, MemReq, MemErr);
        end
        MemAck   = 1'b1;
        MemRData = 32'hCAFE_0001;
        step();
        idle_inputs();
        total++;
        if (ValidW !== 1'b1 || ReadDataW !== 32'hCAFE_0001 || WA3W !== 4'd8) begin
            bad++;
            $display("FAIL late_ack: ValidW=%b ReadDataW=%h WA3W=%0d want 1 cafe0001 8",
                     ValidW, ReadDataW, WA3W);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_flush_access();
        test_flush_idle();
        test_reset_access();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
